// File: rtl/mmv_burst_reader.sv
// Burst read initiator: turns (addr, len) commands into single-word MMV reads
// and streams the returned data through a credit-limited FIFO.
module mmv_burst_reader #(
  parameter int unsigned AWIDTH  = 8,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned LWIDTH  = 8,
  parameter int unsigned MAXPEND = 4
) (
  input  logic              reset_n,
  input  logic              clk,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [LWIDTH-1:0] cmd_len,
  input  logic              cmd_val,
  output logic              cmd_rdy,
  output logic [AWIDTH-1:0] m_addr,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_rval,
  input  logic              m_busy,
  output logic [DWIDTH-1:0] o_dat,
  output logic              o_val,
  input  logic              o_rdy,
  output logic              o_last,
  output logic              busy
);

  localparam int unsigned CW = $clog2(MAXPEND + 1);
  localparam int unsigned PW = $clog2(MAXPEND);
  localparam int unsigned NW = LWIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              rreq_q, rreq_d;
  logic [NW-1:0]     remain_q, remain_d;
  logic [NW-1:0]     popped_q, popped_d;
  logic [LWIDTH-1:0] last_q, last_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [DWIDTH-1:0] mem_q [MAXPEND];
  logic [DWIDTH-1:0] mem_d [MAXPEND];
  logic [DWIDTH-1:0] odat_q, odat_d;
  logic              oval_q, oval_d;
  logic              olast_q, olast_d;
  logic              crdy_q, crdy_d;
  logic              busy_q, busy_d;
  logic              cmd_fire, accept, push, pop;

  // Next-state: handshakes, credit/FIFO bookkeeping, FSM and registered outputs.
  always_comb begin
    cmd_fire = cmd_val && crdy_q;
    accept   = rreq_q && !m_busy;
    push     = m_rval && (outst_q != '0);
    pop      = oval_q && o_rdy;

    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    popped_d = popped_q;
    last_d   = last_q;
    credit_d = credit_q + CW'(accept) - CW'(pop);
    outst_d  = outst_q + CW'(accept) - CW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    wptr_d   = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d   = pop ? rptr_q + PW'(1) : rptr_q;
    mem_d    = mem_q;
    if (push) mem_d[wptr_q] = m_rdat;
    if (pop) popped_d = popped_q + NW'(1);
    if (accept) begin
      addr_d   = addr_q + AWIDTH'(1);
      remain_d = remain_q - NW'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d  = ISSUE;
          addr_d   = cmd_addr;
          remain_d = NW'(cmd_len) + NW'(1);
          last_d   = cmd_len;
          popped_d = '0;
        end
      end
      ISSUE: begin
        if (accept && (remain_d == '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && olast_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A posted request is never withdrawn; a new one needs room after this cycle's traffic.
    if (rreq_q && !accept) begin
      rreq_d = 1'b1;
    end else begin
      rreq_d = (state_d == ISSUE) && (remain_d != '0) && (credit_d < CW'(MAXPEND));
    end

    crdy_d  = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    oval_d  = (count_d != '0);
    olast_d = oval_d && (popped_d == {1'b0, last_d});
    odat_d  = mem_d[rptr_d];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rreq_q   <= 1'b0;
      remain_q <= '0;
      popped_q <= '0;
      last_q   <= '0;
      credit_q <= '0;
      outst_q  <= '0;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      mem_q    <= '{default: '0};
      odat_q   <= '0;
      oval_q   <= 1'b0;
      olast_q  <= 1'b0;
      crdy_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rreq_q   <= rreq_d;
      remain_q <= remain_d;
      popped_q <= popped_d;
      last_q   <= last_d;
      credit_q <= credit_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      mem_q    <= mem_d;
      odat_q   <= odat_d;
      oval_q   <= oval_d;
      olast_q  <= olast_d;
      crdy_q   <= crdy_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd_rdy = crdy_q;
  assign m_addr  = addr_q;
  assign m_rreq  = rreq_q;
  assign m_wreq  = 1'b0;
  assign m_wdat  = '0;
  assign o_dat   = odat_q;
  assign o_val   = oval_q;
  assign o_last  = olast_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mmv_burst_reader.sv
// Directed bench for mmv_burst_reader with a fixed-latency in-order slave model.
module tb_mmv_burst_reader;

  logic       reset_n, clk;
  logic [7:0] cmd_addr, cmd_len;
  logic       cmd_val, cmd_rdy;
  logic [7:0] m_addr, m_wdat, m_rdat, o_dat;
  logic       m_wreq, m_rreq, m_rval, m_busy;
  logic       o_val, o_rdy, o_last, busy;

  mmv_burst_reader dut (
    .reset_n(reset_n), .clk(clk),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .m_addr(m_addr), .m_wreq(m_wreq), .m_wdat(m_wdat), .m_rreq(m_rreq),
    .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy),
    .o_dat(o_dat), .o_val(o_val), .o_rdy(o_rdy), .o_last(o_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] len;
    int         lat;
    int         busy_pct;
    int         rdy_pct;
    logic [7:0] exp_end;
    int         exp_words;
  } vec_t;

  vec_t       vt [7];
  int         n_vec = 0, n_err = 0;
  int         lat = 1, busy_pct = 0, rdy_pct = 100;
  logic       pv [4];
  logic [7:0] pd [4];
  logic [7:0] b_addr;
  int         b_words, acc_cnt, pop_cnt;

  function automatic logic [7:0] memf(input logic [7:0] a);
    return 8'(a * 7) ^ 8'h5C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: score handshakes seen before the edge, then drive the slave and sinks.
  task automatic tick();
    logic       acc, pop, hold, stall;
    logic [7:0] acc_a, h_addr, s_dat;
    acc   = m_rreq && !m_busy;
    acc_a = m_addr;
    pop   = o_val && o_rdy;
    hold  = m_rreq && m_busy;
    h_addr = m_addr;
    stall = o_val && !o_rdy;
    s_dat = o_dat;
    if (acc) begin
      chk("acc_addr", acc_a, 8'(b_addr + acc_cnt));
      acc_cnt++;
    end
    if (pop) begin
      chk("o_dat", o_dat, memf(8'(b_addr + pop_cnt)));
      chk("o_last", o_last, (pop_cnt == b_words - 1));
      pop_cnt++;
    end
    @(posedge clk); #1;
    if (hold) begin
      chk("hold_rreq", m_rreq, 1);
      chk("hold_addr", m_addr, h_addr);
    end
    if (stall) begin
      chk("stall_val", o_val, 1);
      chk("stall_dat", o_dat, s_dat);
    end
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0]  = acc;
    pd[0]  = memf(acc_a);
    m_rval = pv[lat-1];
    m_rdat = pd[lat-1];
    m_busy = (busy_pct == 0) ? 1'b0 : ($urandom_range(99) < busy_pct);
    o_rdy  = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
  endtask

  task automatic start_cmd(input logic [7:0] a, input logic [7:0] l);
    int n;
    b_addr = a; b_words = int'(l) + 1; acc_cnt = 0; pop_cnt = 0;
    cmd_addr = a; cmd_len = l; cmd_val = 1'b1;
    n = 0;
    while (!cmd_rdy && n < 50) begin tick(); n++; end
    chk("cmd_rdy_wait", cmd_rdy, 1);
    tick();
    cmd_val = 1'b0;
    chk("first_rreq", m_rreq, 1);
    chk("first_addr", m_addr, a);
    chk("cmd_rdy_busy", cmd_rdy, 0);
    chk("busy_set", busy, 1);
  endtask

  task automatic finish_burst(input logic [7:0] exp_end, input int exp_words);
    int n, budget;
    budget = exp_words * 20 + 200;
    n = 0;
    while (pop_cnt < b_words && n < budget) begin tick(); n++; end
    chk("words_popped", pop_cnt, exp_words);
    chk("words_read", acc_cnt, exp_words);
    chk("cmd_rdy_after", cmd_rdy, 1);
    chk("busy_after", busy, 0);
    chk("o_val_after", o_val, 0);
    chk("m_rreq_after", m_rreq, 0);
    chk("m_addr_end", m_addr, exp_end);
  endtask

  initial begin
    vt[0] = '{8'h10, 8'd3,   1, 0,  100, 8'h14, 4};
    vt[1] = '{8'hFE, 8'd3,   2, 0,  100, 8'h02, 4};
    vt[2] = '{8'h40, 8'd15,  1, 50, 100, 8'h50, 16};
    vt[3] = '{8'h00, 8'hFF,  1, 0,  100, 8'h00, 256};
    vt[4] = '{8'h80, 8'd0,   3, 0,  100, 8'h81, 1};
    vt[5] = '{8'h33, 8'd9,   3, 30, 60,  8'h3D, 10};
    vt[6] = '{8'hF0, 8'd31,  2, 25, 50,  8'h10, 32};

    for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    reset_n = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_val = 1'b0;
    m_rdat = '0; m_rval = 1'b0; m_busy = 1'b0; o_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_m_rreq", m_rreq, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_o_val", o_val, 0);
    chk("rst_o_dat", o_dat, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_busy", busy, 0);
    chk("m_wreq", m_wreq, 0);
    chk("m_wdat", m_wdat, 0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      lat = vt[v].lat; busy_pct = vt[v].busy_pct; rdy_pct = vt[v].rdy_pct;
      start_cmd(vt[v].addr, vt[v].len);
      finish_burst(vt[v].exp_end, vt[v].exp_words);
      repeat (2) tick();
    end

    // Sink stalled: issue stops at the credit limit, then resumes with no loss.
    lat = 1; busy_pct = 0; rdy_pct = 0; o_rdy = 1'b0; m_busy = 1'b0;
    start_cmd(8'h10, 8'd7);
    repeat (10) tick();
    chk("credit_accepts", acc_cnt, 4);
    chk("credit_rreq", m_rreq, 0);
    chk("credit_oval", o_val, 1);
    chk("credit_head", o_dat, memf(8'h10));
    chk("credit_olast", o_last, 0);
    rdy_pct = 100; o_rdy = 1'b1;
    finish_burst(8'h18, 8);
    repeat (2) tick();

    // Reset mid-burst with two reads outstanding; late responses must be dropped.
    lat = 3; busy_pct = 0; rdy_pct = 100; m_busy = 1'b0;
    start_cmd(8'h60, 8'd7);
    begin
      int n;
      n = 0;
      while (acc_cnt < 2 && n < 20) begin tick(); n++; end
    end
    chk("two_accepted", acc_cnt, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rreq", m_rreq, 0);
    chk("mid_rst_addr", m_addr, 0);
    chk("mid_rst_oval", o_val, 0);
    chk("mid_rst_odat", o_dat, 0);
    chk("mid_rst_olast", o_last, 0);
    chk("mid_rst_cmd_rdy", cmd_rdy, 1);
    chk("mid_rst_busy", busy, 0);
    #1 reset_n = 1'b1;
    repeat (5) begin
      tick();
      chk("late_rval_ignored", o_val, 0);
    end
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    lat = 1;
    start_cmd(8'h20, 8'd5);
    finish_burst(8'h26, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
